// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one signed MAC sequenced over NTAPS taps per sample
// Ports: clk, reset (sync, active-high); x_in/x_valid/x_ready sample handshake;
//   coef_we/coef_addr/coef_wdata coefficient write, coef_err dropped-write pulse;
//   y_out/y_valid filter output and one-cycle update pulse; busy while accumulating.
// Define FIR_SEQ_SAT_EN to saturate y_out instead of wrapping it.
module fir_mac_sequencer #(
  parameter int NTAPS = 4,
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int OW = 16,
  localparam int AW = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_err,
  output logic signed [OW-1:0] y_out,
  output logic                 y_valid,
  output logic                 busy
);
  localparam int ACCW = DW + CW + AW;
  localparam bit POW2 = NTAPS == (1 << AW);
  typedef enum logic {IDLE, MAC} state_t;
  state_t state, state_n;
  logic signed [DW-1:0] x_reg [NTAPS];
  logic signed [CW-1:0] coef [NTAPS];
  logic signed [ACCW-1:0] acc, sum;
  logic signed [DW+CW-1:0] prod;
  logic signed [OW-1:0] y_fmt;
  logic [AW-1:0] tap;
  logic take, last, addr_ok;
`ifdef FIR_SEQ_SAT_EN
  localparam logic signed [ACCW-1:0] YMAX = ACCW'(2 ** (OW - 1) - 1);
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    x_ready = state == IDLE;
    busy = state == MAC;
    take = x_valid && x_ready;
    last = busy && tap == AW'(NTAPS - 1);
    state_n = take ? MAC : last ? IDLE : state;
    addr_ok = POW2 || (32'(coef_addr) < NTAPS);
    prod = (DW+CW)'(coef[tap]) * (DW+CW)'(x_reg[tap]);
    sum = acc + ACCW'(prod);
`ifdef FIR_SEQ_SAT_EN
    y_fmt = sum > YMAX ? OW'(YMAX) : sum < YMIN ? OW'(YMIN) : sum[OW-1:0];
`else
    y_fmt = sum[OW-1:0];
`endif
  end
  // The coefficient write lands at the same edge that accepts a sample, so the
  // MAC pass that follows already sees the new value.
  always_ff @(posedge clk)
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_reg[k] <= '0;
        coef[k] <= CW'(k + 1);
      end
      acc <= '0;
      tap <= '0;
      y_out <= '0;
      y_valid <= 1'b0;
      coef_err <= 1'b0;
    end else begin
      y_valid <= last;
      coef_err <= coef_we && (busy || !addr_ok);
      if (coef_we && !busy && addr_ok) coef[coef_addr] <= coef_wdata;
      if (take) begin
        x_reg[0] <= x_in;
        for (int k = 1; k < NTAPS; k++) x_reg[k] <= x_reg[k-1];
        acc <= '0;
        tap <= '0;
      end else if (busy) begin
        acc <= sum;
        tap <= tap + 1'b1;
      end
      if (last) y_out <= y_fmt;
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed and random checks of fir_mac_sequencer against a dot-product model
module tb_fir_mac_sequencer;
  logic clk = 0, reset = 1;
  logic signed [7:0] x_in = 0;
  logic x_valid = 0, x_ready;
  logic coef_we = 0;
  logic [1:0] coef_addr = 0;
  logic signed [7:0] coef_wdata = 0;
  logic coef_err;
  logic signed [15:0] y_out;
  logic y_valid, busy;
  int total = 0, bad = 0, cyc = 0, t0 = 0;
  int hist [4];
  int cm [4];
  logic [15:0] expq [$];

  fir_mac_sequencer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
    .y_out(y_out), .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic void mreset();
    for (int k = 0; k < 4; k++) begin
      hist[k] = 0;
      cm[k] = k + 1;
    end
    expq.delete();
  endfunction

  function automatic logic [15:0] model_y();
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(cm[k]) * longint'(hist[k]);
`ifdef FIR_SEQ_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  function automatic void mpush(input int x);
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    expq.push_back(model_y());
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    mreset();
  endtask

  task automatic wcoef(input int a, input int d);
    coef_we = 1;
    coef_addr = 2'(a);
    coef_wdata = 8'(d);
    @(negedge clk);
    coef_we = 0;
    cm[a] = d;
    chk("coef_err_idle", int'(coef_err), 0);
  endtask

  task automatic accept(input int x, input bit we, input int a, input int d);
    int n = 0;
    while (!x_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(x_ready), 1);
    x_in = 8'(x);
    x_valid = 1;
    coef_we = we;
    coef_addr = 2'(a);
    coef_wdata = 8'(d);
    @(negedge clk);
    x_valid = 0;
    coef_we = 0;
    t0 = cyc - 1;
    if (we) cm[a] = d;
    mpush(x);
    chk("busy", int'(busy), 1);
  endtask

  task automatic wait_y(input string tag);
    int n = 0;
    while (!y_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, int'(y_valid), 1);
    chk({tag, "_lat"}, cyc - t0, 5);
    if (expq.size() > 0) chk(tag, int'($unsigned(y_out)), int'(expq.pop_front()));
    else chk({tag, "_noexp"}, 0, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(y_valid), 0);
  endtask

  initial begin
    int ready_low, nout, seen, r;
    mreset();
    do_reset();
    chk("rst_y", int'($unsigned(y_out)), 0);
    chk("rst_vld", int'(y_valid), 0);
    chk("rst_ready", int'(x_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(coef_err), 0);

    accept(1, 0, 0, 0);
    wait_y("imp");
    for (int i = 0; i < 4; i++) begin
      accept(0, 0, 0, 0);
      wait_y("imp");
    end

    do_reset();
    x_in = 10;
    x_valid = 1;
    ready_low = 0;
    nout = 0;
    for (int n = 0; n < 26; n++) begin
      if (y_valid) begin
        chk("step_y", int'($unsigned(y_out)), int'(expq.pop_front()));
        nout++;
      end
      if (x_ready) mpush(10);
      else ready_low++;
      @(negedge clk);
    end
    x_valid = 0;
    r = 0;
    while (!y_valid && r < 20) begin
      @(negedge clk);
      r++;
    end
    chk("step_last_vld", int'(y_valid), 1);
    chk("step_last", int'($unsigned(y_out)), int'(expq.pop_front()));
    chk("step_last_val", int'(y_out), 100);
    chk("step_ready_low", ready_low, 20);
    chk("step_nout", nout, 5);
    @(negedge clk);

    do_reset();
    wcoef(0, -1);
    accept(5, 0, 0, 0);
    wait_y("neg0");
    chk("neg0_val", int'(y_out), -5);
    for (int i = 0; i < 3; i++) begin
      accept(0, 0, 0, 0);
      wait_y("neg");
    end

    do_reset();
    accept(1, 0, 0, 0);
    coef_we = 1;
    coef_addr = 1;
    coef_wdata = 0;
    @(negedge clk);
    coef_we = 0;
    chk("mac_err", int'(coef_err), 1);
    @(negedge clk);
    chk("mac_err_pulse", int'(coef_err), 0);
    wait_y("macw");
    accept(0, 0, 0, 0);
    wait_y("macw");
    chk("macw_val", int'(y_out), 2);

    do_reset();
    accept(2, 1, 0, 7);
    wait_y("same_cycle");
    chk("same_cycle_val", int'(y_out), 14);

    do_reset();
    for (int k = 0; k < 4; k++) wcoef(k, 127);
    for (int i = 0; i < 4; i++) begin
      accept(-128, 0, 0, 0);
      wait_y("sat");
    end
`ifdef FIR_SEQ_SAT_EN
    chk("sat4", int'($unsigned(y_out)), 32'h8000);
`else
    chk("sat4", int'($unsigned(y_out)), 32'h0200);
`endif

    do_reset();
    accept(3, 0, 0, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    mreset();
    chk("abort_ready", int'(x_ready), 1);
    chk("abort_y", int'($unsigned(y_out)), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen |= int'(y_valid);
      @(negedge clk);
    end
    chk("abort_no_vld", seen, 0);
    accept(1, 0, 0, 0);
    wait_y("abort_imp");
    accept(0, 0, 0, 0);
    wait_y("abort_imp");
    chk("abort_coef1", int'(y_out), 2);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 3));
      if (r == 0) wcoef(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
      accept(int'($urandom_range(0, 255)) - 128, r == 1,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)) - 128);
      wait_y("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
